// File: rtl/branch_predictor_if.sv
// Fetch-lookup / EX-resolution bus between the pipeline and the branch predictor.
//   master : pipeline side, drives if_pc and the EX resolution fields,
//            receives the prediction, resolution result and counters.
//   slave  : branch predictor side.
interface branch_predictor_if;
   logic [31:0] if_pc;
   logic        branch_estimation;
   logic [31:0] branch_target;
   logic        ex_branch_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_predicted_taken;
   logic [31:0] ex_predicted_target;
   logic        branch_prediction_miss;
   logic [31:0] branch_target_actual;
   logic [31:0] branch_count;
   logic [31:0] miss_count;

   modport master (
      output if_pc, ex_branch_valid, ex_pc, ex_taken, ex_target,
             ex_predicted_taken, ex_predicted_target,
      input  branch_estimation, branch_target, branch_prediction_miss,
             branch_target_actual, branch_count, miss_count
   );

   modport slave (
      input  if_pc, ex_branch_valid, ex_pc, ex_taken, ex_target,
             ex_predicted_taken, ex_predicted_target,
      output branch_estimation, branch_target, branch_prediction_miss,
             branch_target_actual, branch_count, miss_count
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, trained by EX resolution.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bp    : slave side of branch_predictor_if
//           IF lookup  -> branch_estimation / branch_target (combinational)
//           EX resolve -> branch_prediction_miss / branch_target_actual (combinational)
//           branch_count / miss_count are registered wrap-around counters
module branch_predictor #(
   parameter int unsigned IDX_BITS = 4,
   parameter logic [1:0]  CTR_INIT = 2'b10
) (
   input logic              clk,
   input logic              reset,
   branch_predictor_if.slave bp
);
   localparam int unsigned ENTRIES  = 1 << IDX_BITS;
   localparam int unsigned TAG_LSB  = IDX_BITS + 2;
   localparam int unsigned TAG_BITS = 32 - TAG_LSB;

   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];
   logic [31:0]         branch_count_q;
   logic [31:0]         miss_count_q;

   // Fetch-side lookup
   logic [IDX_BITS-1:0] if_idx;
   logic [TAG_BITS-1:0] if_tag;
   logic                if_hit;
   logic                unused_if_pc_lsbs;

   assign if_idx            = bp.if_pc[TAG_LSB-1:2];
   assign if_tag            = bp.if_pc[31:TAG_LSB];
   assign if_hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign unused_if_pc_lsbs = ^bp.if_pc[1:0];

   assign bp.branch_estimation = if_hit && ctr_q[if_idx][1];
   assign bp.branch_target     = if_hit ? target_q[if_idx] : 32'd0;

   // EX-side resolution result
   logic        miss_c;
   logic [31:0] target_actual_c;

   always_comb begin
      miss_c          = 1'b0;
      target_actual_c = 32'd0;
      if (bp.ex_branch_valid) begin
         miss_c = (bp.ex_taken != bp.ex_predicted_taken) ||
                  (bp.ex_taken && (bp.ex_predicted_target != bp.ex_target));
         target_actual_c = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;
      end
   end

   assign bp.branch_prediction_miss = miss_c;
   assign bp.branch_target_actual   = target_actual_c;
   assign bp.branch_count           = branch_count_q;
   assign bp.miss_count             = miss_count_q;

   // Next contents of the entry addressed by ex_pc
   logic [IDX_BITS-1:0] ex_idx;
   logic [TAG_BITS-1:0] ex_tag;
   logic                ex_hit;
   logic                wr_en;
   logic [TAG_BITS-1:0] tag_d;
   logic [31:0]         target_d;
   logic [1:0]          ctr_d;

   assign ex_idx = bp.ex_pc[TAG_LSB-1:2];
   assign ex_tag = bp.ex_pc[31:TAG_LSB];
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   always_comb begin
      wr_en    = 1'b0;
      tag_d    = tag_q[ex_idx];
      target_d = target_q[ex_idx];
      ctr_d    = ctr_q[ex_idx];
      if (bp.ex_branch_valid) begin
         if (ex_hit) begin
            wr_en = 1'b1;
            if (bp.ex_taken) begin
               if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'd1;
               target_d = bp.ex_target;
            end else if (ctr_q[ex_idx] != 2'b00) begin
               ctr_d = ctr_q[ex_idx] - 2'd1;
            end
         end else if (bp.ex_taken) begin
            // Allocation overwrites whatever aliased into this slot
            wr_en    = 1'b1;
            tag_d    = ex_tag;
            target_d = bp.ex_target;
            ctr_d    = CTR_INIT;
         end
      end
   end

   // BTB storage and performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'd0;
            ctr_q[i]    <= 2'b01;
         end
         branch_count_q <= 32'd0;
         miss_count_q   <= 32'd0;
      end else begin
         if (wr_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= tag_d;
            target_q[ex_idx] <= target_d;
            ctr_q[ex_idx]    <= ctr_d;
         end
         if (bp.ex_branch_valid) branch_count_q <= branch_count_q + 32'd1;
         if (miss_c)             miss_count_q   <= miss_count_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the stimulus process computes each
// cycle's expected outputs from a behavioural BTB model and queues them; the
// monitor process pops and compares on every falling edge.
module tb_branch_predictor;
   localparam int ENTRIES = 16;

   logic clk;
   logic reset;

   branch_predictor_if bp_if ();

   branch_predictor #(.IDX_BITS(4), .CTR_INIT(2'b10)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        est;
      bit [31:0] tgt;
      bit        miss;
      bit [31:0] tact;
      bit [31:0] bcnt;
      bit [31:0] mcnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: each slot remembers the word-address tag of its owner
   bit        m_valid [ENTRIES];
   bit [31:0] m_tag   [ENTRIES];
   bit [31:0] m_tgt   [ENTRIES];
   int        m_ctr   [ENTRIES];
   bit [31:0] m_bcnt;
   bit [31:0] m_mcnt;

   function automatic int idx_of(input bit [31:0] pc);
      return int'((pc >> 2) % 32'd16);
   endfunction

   function automatic bit [31:0] tag_of(input bit [31:0] pc);
      return pc >> 6;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 32'd0;
         m_tgt[i]   = 32'd0;
         m_ctr[i]   = 1;
      end
      m_bcnt = 32'd0;
      m_mcnt = 32'd0;
   endfunction

   function automatic void model_lookup(input bit [31:0] pc, output bit est, output bit [31:0] tgt);
      int  i;
      bit  hit;
      i   = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(pc));
      est = hit && (m_ctr[i] >= 2);
      tgt = hit ? m_tgt[i] : 32'd0;
   endfunction

   function automatic void model_update(input bit [31:0] pc, input bit tk, input bit [31:0] tgt, input bit miss);
      int i;
      i = idx_of(pc);
      if (m_valid[i] && (m_tag[i] == tag_of(pc))) begin
         if (tk) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = tgt;
         end else begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
         end
      end else if (tk) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = tag_of(pc);
         m_tgt[i]   = tgt;
         m_ctr[i]   = 2;
      end
      m_bcnt = m_bcnt + 32'd1;
      if (miss) m_mcnt = m_mcnt + 32'd1;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; mid_rst raises reset shortly after the inputs change
   task automatic step(input bit rst_v, input bit mid_rst, input bit [31:0] ifpc,
                       input bit bv, input bit [31:0] expc, input bit tk,
                       input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
      exp_t e;
      @(posedge clk);
      #1;
      reset                        = rst_v;
      bp_if.if_pc                  = ifpc;
      bp_if.ex_branch_valid        = bv;
      bp_if.ex_pc                  = expc;
      bp_if.ex_taken               = tk;
      bp_if.ex_target              = tgt;
      bp_if.ex_predicted_taken     = ptk;
      bp_if.ex_predicted_target    = ptgt;
      if (mid_rst) begin
         #1;
         reset = 1'b1;
      end
      if (reset) model_reset();
      model_lookup(ifpc, e.est, e.tgt);
      e.miss = bv && ((tk != ptk) || (tk && (ptgt != tgt)));
      e.tact = !bv ? 32'd0 : (tk ? tgt : expc + 32'd4);
      e.bcnt = m_bcnt;
      e.mcnt = m_mcnt;
      sb_q.push_back(e);
      if (!reset && bv) model_update(expc, tk, tgt, e.miss);
   endtask

   task automatic lookup(input bit [31:0] ifpc);
      step(1'b0, 1'b0, ifpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic resolve(input bit [31:0] ifpc, input bit [31:0] expc, input bit tk,
                          input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
      step(1'b0, 1'b0, ifpc, 1'b1, expc, tk, tgt, ptk, ptgt);
   endtask

   // Monitor: outputs are presented every cycle, compare against queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check32("estimation",    32'(bp_if.branch_estimation),      32'(e.est));
         check32("target",        bp_if.branch_target,               e.tgt);
         check32("miss",          32'(bp_if.branch_prediction_miss), 32'(e.miss));
         check32("target_actual", bp_if.branch_target_actual,        e.tact);
         check32("branch_count",  bp_if.branch_count,                e.bcnt);
         check32("miss_count",    bp_if.miss_count,                  e.mcnt);
      end
   end

   function automatic bit [31:0] rand_pc();
      return 32'h1000 | (32'($urandom_range(0, 3)) << 6) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      bit [31:0] ifpc, expc, tgt, ptgt;
      bit        tk, ptk, bv, mid;
      int        budget;

      reset                     = 1'b1;
      bp_if.if_pc               = 32'd0;
      bp_if.ex_branch_valid     = 1'b0;
      bp_if.ex_pc               = 32'd0;
      bp_if.ex_taken            = 1'b0;
      bp_if.ex_target           = 32'd0;
      bp_if.ex_predicted_taken  = 1'b0;
      bp_if.ex_predicted_target = 32'd0;
      model_reset();

      step(1'b1, 1'b0, 32'h100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'h100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);

      // Cold start
      lookup(32'h100);
      resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
      lookup(32'h100);

      // Hysteresis
      resolve(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      lookup(32'h100);
      for (int i = 0; i < 5; i++) resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
      resolve(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      lookup(32'h100);

      // Alias eviction
      resolve(32'h100, 32'h140, 1'b1, 32'h200, 1'b0, 32'd0);
      lookup(32'h100);
      lookup(32'h140);

      // Wrong target
      resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
      resolve(32'h100, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
      lookup(32'h100);

      // Fall-through at the address wrap, no allocation on not-taken miss
      resolve(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 32'h40);
      lookup(32'hFFFF_FFFC);

      // Same-cycle read sees old contents, then reset during an update
      resolve(32'h100, 32'h100, 1'b1, 32'hA0, 1'b1, 32'h90);
      lookup(32'h100);
      step(1'b0, 1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h300, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h300, 1'b0, 32'd0);
      lookup(32'h180);
      lookup(32'h100);

      // Randomized traffic over a small PC pool so entries hit and alias
      for (int n = 0; n < 600; n++) begin
         expc = rand_pc();
         ifpc = ($urandom_range(0, 3) == 0) ? expc : rand_pc();
         bv   = ($urandom_range(0, 3) != 0);
         tk   = $urandom_range(0, 1) == 1;
         tgt  = 32'($urandom_range(0, 7)) << 4;
         if ($urandom_range(0, 3) != 0) begin
            model_lookup(expc, ptk, ptgt);
         end else begin
            ptk  = $urandom_range(0, 1) == 1;
            ptgt = 32'($urandom_range(0, 7)) << 4;
         end
         mid = ($urandom_range(0, 99) == 0);
         step(1'b0, mid, ifpc, bv, expc, tk, tgt, ptk, ptgt);
      end
      lookup(32'h1000);

      budget = 0;
      while (sb_q.size() > 0 && budget < 10) begin
         @(negedge clk);
         #1;
         budget++;
      end
      check32("scoreboard_drain", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
